// File: rtl/pc_gen_unit_pkg.sv
// Shared definitions for the next-PC generator: address bus width, default
// vectors and the BOOT/RUN state encodings.
package pc_gen_unit_pkg;

  localparam int INST_ADDR_BUS_W = 32;

  localparam logic [INST_ADDR_BUS_W-1:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [INST_ADDR_BUS_W-1:0] EXC_VEC_DEF   = 32'h0000_0020;

  localparam logic [0:0] STATE_BOOT = 1'b0;
  localparam logic [0:0] STATE_RUN  = 1'b1;

endpackage

// File: rtl/pc_ras_stack.sv
// Circular return-address stack: push/pop/flush, overflow overwrites the
// oldest entry, pop-and-push in one cycle replaces the top.
module pc_ras_stack #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_push_addr,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop_ok;
  logic [PTR_W-1:0]  w_ptr_inc;
  logic [PTR_W-1:0]  w_ptr_dec;
  logic [PTR_W-1:0]  w_wr_ptr;

  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_ptr_inc = (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
  assign w_ptr_dec = (r_ptr == '0) ? LAST_IDX : r_ptr - 1'b1;
  // Pop-then-push writes over the current top instead of advancing.
  assign w_wr_ptr  = w_pop_ok ? r_ptr : w_ptr_inc;

  assign o_top   = r_mem[r_ptr];
  assign o_empty = (r_count == '0);

  // NOTE: non-blocking (<=) in every clocked block so all registers update
  // together from pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push && !w_pop_ok) begin
      r_ptr   <= w_ptr_inc;
      r_count <= (r_count == FULL_CNT) ? FULL_CNT : r_count + 1'b1;
    end else if (w_pop_ok && !i_push) begin
      r_ptr   <= w_ptr_dec;
      r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; r_count marks which entries are
  // meaningful, so resetting the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[w_wr_ptr] <= i_push_addr;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Next-PC generator: owns the PC, prioritises exception/eret/branch/pending/
// sequential sources, fetch handshake. Optional return stack under PC_RAS_EN.
module pc_gen_unit
  import pc_gen_unit_pkg::*;
#(
  parameter int                 ADDR_W     = INST_ADDR_BUS_W,
  parameter int                 INST_BYTES = 4,
  parameter logic [ADDR_W-1:0]  RESET_VEC  = RESET_VEC_DEF,
  parameter logic [ADDR_W-1:0]  EXC_VEC    = EXC_VEC_DEF,
  parameter int                 RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              exc_i,
  input  logic              eret_i,
  input  logic [ADDR_W-1:0] epc_i,
  input  logic              if_ready_i,
  input  logic              call_i,
  input  logic              ret_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pc_valid_o,
  output logic [ADDR_W-1:0] pc_plus_inc_o,
  output logic              redirect_o,
  output logic              misalign_o
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INST_BYTES - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_redirect;
  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_target;

  logic [ADDR_W-1:0] w_pc_next;
  logic              w_redirect_next;
  logic              w_pend_valid_next;
  logic [ADDR_W-1:0] w_pend_target_next;
  logic              w_run;

  assign w_run         = (r_state == STATE_RUN);
  assign pc_o          = r_pc;
  assign pc_valid_o    = w_run;
  assign pc_plus_inc_o = r_pc + ADDR_W'(INST_BYTES);
  assign redirect_o    = r_redirect;
  assign misalign_o    = |(r_pc & ALIGN_MASK);

`ifdef PC_RAS_EN
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;
  logic              w_ras_pop;

  pc_ras_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_run && call_i),
    .i_pop       (w_ras_pop),
    .i_flush     (w_run && exc_i),
    .i_push_addr (pc_plus_inc_o),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty)
  );
`else
  logic w_unused;
  assign w_unused = call_i ^ ret_i ^ (RAS_DEPTH > 0);
`endif

  // NOTE: every always_comb output gets a default first, so no path through
  // the priority chain leaves a signal unassigned and infers a latch.
  always_comb begin
    w_pc_next          = r_pc;
    w_redirect_next    = 1'b0;
    w_pend_valid_next  = r_pend_valid;
    w_pend_target_next = r_pend_target;
`ifdef PC_RAS_EN
    w_ras_pop          = 1'b0;
`endif
    if (w_run) begin
      if (exc_i) begin
        w_pc_next         = EXC_VEC;
        w_redirect_next   = 1'b1;
        w_pend_valid_next = 1'b0;
      end else if (eret_i) begin
        w_pc_next         = epc_i;
        w_redirect_next   = 1'b1;
        w_pend_valid_next = 1'b0;
      end else if (branch_i) begin
        // Applied at once; also captured so the target survives the stall.
        w_pc_next          = branch_target_i;
        w_redirect_next    = 1'b1;
        w_pend_valid_next  = stall_i;
        w_pend_target_next = branch_target_i;
      end else if (r_pend_valid && !stall_i) begin
        w_pc_next         = r_pend_target;
        w_pend_valid_next = 1'b0;
`ifdef PC_RAS_EN
      end else if (ret_i && !w_ras_empty) begin
        w_pc_next       = w_ras_top;
        w_redirect_next = 1'b1;
        w_ras_pop       = 1'b1;
`endif
      end else if (stall_i || !if_ready_i) begin
        w_pc_next = r_pc;
      end else begin
        w_pc_next = pc_plus_inc_o;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= STATE_BOOT;
      r_pc          <= RESET_VEC;
      r_redirect    <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_state       <= STATE_RUN;
      r_pc          <= w_pc_next;
      r_redirect    <= w_redirect_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_target <= w_pend_target_next;
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: per-cycle stimulus with expected
// PC/valid/redirect pushed to a scoreboard queue and compared after each edge.
module tb_pc_gen_unit;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        br;
    logic        exc;
    logic        eret;
    logic        call;
    logic        ret;
    logic [31:0] addr;
    logic [31:0] exp_pc;
    logic        exp_redir;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        redir;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, branch_i, exc_i, eret_i, if_ready_i, call_i, ret_i;
  logic [31:0] branch_target_i, epc_i;
  logic [31:0] pc_o, pc_plus_inc_o;
  logic        pc_valid_o, redirect_o, misalign_o;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pc_gen_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .exc_i           (exc_i),
    .eret_i          (eret_i),
    .epc_i           (epc_i),
    .if_ready_i      (if_ready_i),
    .call_i          (call_i),
    .ret_i           (ret_i),
    .pc_o            (pc_o),
    .pc_valid_o      (pc_valid_o),
    .pc_plus_inc_o   (pc_plus_inc_o),
    .redirect_o      (redirect_o),
    .misalign_o      (misalign_o)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic stall, input logic ready, input logic br,
                               input logic exc, input logic eret, input logic call,
                               input logic ret, input logic [31:0] addr,
                               input logic [31:0] exp_pc, input logic exp_redir);
    stim_t s;
    s.stall = stall; s.ready = ready; s.br = br; s.exc = exc; s.eret = eret;
    s.call = call; s.ret = ret; s.addr = addr; s.exp_pc = exp_pc; s.exp_redir = exp_redir;
    return s;
  endfunction

  // Drives one cycle of inputs, queues its expectation, advances past the edge.
  task automatic run_step(input stim_t s);
    exp_t e;
    stall_i = s.stall; if_ready_i = s.ready; branch_i = s.br; exc_i = s.exc;
    eret_i = s.eret; call_i = s.call; ret_i = s.ret;
    branch_target_i = s.addr; epc_i = s.addr;
    e.pc = s.exp_pc; e.valid = 1'b1; e.redir = s.exp_redir;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input string name, input stim_t s[$]);
    exp_t        e;
    logic        exp_mis;
    logic [31:0] exp_inc;
    foreach (s[i]) begin
      run_step(s[i]);
      e = exp_q.pop_front();
      exp_mis = |e.pc[1:0];
      exp_inc = e.pc + 32'd4;
      checks++;
      if (pc_o !== e.pc || pc_valid_o !== e.valid || redirect_o !== e.redir ||
          misalign_o !== exp_mis || pc_plus_inc_o !== exp_inc) begin
        errors++;
        $display("FAIL %s[%0d]: got pc=%h valid=%b redir=%b mis=%b inc=%h, want pc=%h valid=%b redir=%b mis=%b inc=%h",
                 name, i, pc_o, pc_valid_o, redirect_o, misalign_o, pc_plus_inc_o,
                 e.pc, e.valid, e.redir, exp_mis, exp_inc);
      end
    end
  endtask

  task automatic test_reset;
    stim_t s[$];
    rst_n = 1'b0; stall_i = 0; branch_i = 0; exc_i = 0; eret_i = 0;
    if_ready_i = 1; call_i = 0; ret_i = 0; branch_target_i = '0; epc_i = '0;
    #12;
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got pc=%h valid=%b redir=%b, want pc=00000000 valid=0 redir=0",
               pc_o, pc_valid_o, redirect_o);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (pc_valid_o !== 1'b0 || pc_o !== 32'h0) begin
      errors++;
      $display("FAIL boot_cycle: got pc=%h valid=%b, want pc=00000000 valid=0", pc_o, pc_valid_o);
    end
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h4, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h8, 0));
    run_seq("reset_seq", s);
  endtask

  task automatic test_handshake;
    stim_t s[$];
    for (int k = 0; k < 3; k++) s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'hC, 0));
    run_seq("handshake", s);
  endtask

  task automatic test_stall_branch;
    stim_t s[$];
    s.push_back(mk(1, 1, 1, 0, 0, 0, 0, 32'h100, 32'h100, 1));
    s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,       32'h100, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,       32'h100, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,       32'h104, 0));
    // Two branches in one stall: last target wins.
    s.push_back(mk(1, 1, 1, 0, 0, 0, 0, 32'h200, 32'h200, 1));
    s.push_back(mk(1, 1, 1, 0, 0, 0, 0, 32'h300, 32'h300, 1));
    s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,       32'h300, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,       32'h300, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,       32'h304, 0));
    s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,       32'h304, 0));
    run_seq("stall_branch", s);
  endtask

  task automatic test_exception;
    stim_t s[$];
    s.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h200, 32'h20, 1));
    s.push_back(mk(0, 1, 0, 0, 1, 0, 0, 32'h44,  32'h44, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,       32'h48, 0));
    s.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0,       32'h20, 1));
    s.push_back(mk(1, 0, 0, 0, 1, 0, 0, 32'h60,  32'h60, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,       32'h64, 0));
    run_seq("exception", s);
  endtask

  task automatic test_misalign_wrap;
    stim_t s[$];
    s.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h102,       32'h102,       1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,             32'h106,       0));
    s.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,             32'h0,         0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,             32'h4,         0));
    run_seq("misalign_wrap", s);
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras;
    stim_t s[$];
    s.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h10, 32'h10, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0,      32'h14, 0));
    s.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h80, 32'h80, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0,      32'h14, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0,      32'h18, 0));
    s.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h100, 32'h100, 1));
    for (int k = 1; k <= 5; k++) s.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 32'h100 + 32'(4 * k), 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 32'h114, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 32'h110, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 32'h10C, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 32'h108, 1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 32'h10C, 0));
    // Exception flushes the stack: the following return finds it empty.
    s.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 32'h110, 0));
    s.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 32'h20,  1));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 32'h24,  0));
    run_seq("ras", s);
  endtask
`endif

  task automatic test_async_reset;
    stim_t s[$];
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pc=%h valid=%b redir=%b, want pc=00000000 valid=0 redir=0",
               pc_o, pc_valid_o, redirect_o);
    end
    rst_n = 1'b1;
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0));
    s.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 32'h4, 0));
    run_seq("after_reset", s);
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_stall_branch();
    test_exception();
    test_misalign_wrap();
`ifdef PC_RAS_EN
    test_ras();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised next-PC generator, the successor to the single-cycle next-address mux.
- Owns the architectural PC register and selects the next fetch address from: reset vector, exception vector, exception return, branch/jump redirect, or sequential increment.
- Adds a fetch valid/ready handshake, a stall-safe pending-redirect latch and misalignment detection.
- Sits between the control unit / EX-stage branch resolution and the instruction-fetch stage.

Parameters:
- ADDR_W, 32, PC width in bits.
- INST_BYTES, 4, sequential increment in bytes; must be a power of two.
- RESET_VEC, 32'h0000_0000, first fetched PC after reset.
- EXC_VEC, 32'h0000_0020, exception entry address.
- RAS_DEPTH, 4, return-address-stack entries; only used with PC_RAS_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  pipeline stall; holds the PC.
- branch_i  in  1  redirect request (branch taken / jump).
- branch_target_i  in  ADDR_W  redirect target.
- exc_i  in  1  exception taken.
- eret_i  in  1  exception return.
- epc_i  in  ADDR_W  exception return address.
- if_ready_i  in  1  fetch stage accepts pc_o this cycle.
- call_i  in  1  call instruction retired (push); ignored without PC_RAS_EN.
- ret_i  in  1  return predicted (pop and redirect); ignored without PC_RAS_EN.
- pc_o  out  ADDR_W  current fetch address.
- pc_valid_o  out  1  pc_o is valid for fetch.
- pc_plus_inc_o  out  ADDR_W  pc_o + INST_BYTES, combinational.
- redirect_o  out  1  the PC update this cycle was non-sequential; fetch drops in-flight work.
- misalign_o  out  1  pc_o low log2(INST_BYTES) bits are non-zero.

Behaviour:
- Reset (async, rst_n=0): pc_o=RESET_VEC, pc_valid_o=0, redirect_o=0, pending latch cleared, RAS empty, state=BOOT.
- FSM states:
  - BOOT: one cycle with pc_valid_o=0, then RUN unconditionally.
  - RUN: pc_valid_o=1.
  - No other states.
- Next-PC priority, evaluated each cycle in RUN (highest first):
  - exc_i → EXC_VEC.
  - eret_i → epc_i.
  - branch_i → branch_target_i.
  - pending latch valid and !stall_i → latched target.
  - ret_i with RAS non-empty → RAS top.
  - stall_i or (pc_valid_o and !if_ready_i) → hold.
  - else → pc_o + INST_BYTES.
- exc_i, eret_i and branch_i override stall and handshake. They load the PC next edge and set redirect_o=1 for that one cycle.
- A redirect that arrives in the cycle it overrides clears any pending latch.
- Pending latch: a branch_i arriving while stall_i=1 is applied immediately and also captured. The PC stays at the target while the stall persists.
- A second branch_i during the same stall overwrites the latch (last wins).
- Latch clears when stall_i falls.
- Sequential addition wraps modulo 2^ADDR_W; no carry out.
- misalign_o is combinational from pc_o. The PC is still issued when misaligned; the exception is raised downstream.
- Handshake: pc_o must stay stable while pc_valid_o=1 and if_ready_i=0, unless a redirect occurs.
- BOOT ignores all request inputs.
- Reset asserted mid-operation returns to BOOT within the same cycle (async).

Optional Feature:
- PC_RAS_EN defined:
  - RAS_DEPTH-entry circular return-address stack.
  - call_i pushes pc_plus_inc_o; overflow overwrites the oldest entry.
  - ret_i pops and redirects (redirect_o=1); pop on empty is ignored with no redirect.
  - Simultaneous call_i and ret_i: pop then push, so the top is replaced.
  - exc_i flushes the stack.
- PC_RAS_EN undefined: call_i and ret_i are ignored, no stack storage exists, and the ret_i priority slot is absent.

Decomposition:
- Shared package/macros file: `InstAddrBus width, RESET_VEC/EXC_VEC defaults, and FSM state encodings (BOOT=1'b0, RUN=1'b1).
- One natural sub-module: pc_ras_stack (push/pop/flush, depth-parametrised), instantiated only under PC_RAS_EN.

Test Plan:
- Reset release → pc_valid_o=0 for one cycle, then pc_o=0x0 valid, then 0x4, 0x8 with if_ready_i=1.
- if_ready_i=0 for 3 cycles at pc_o=0x8 → pc_o holds 0x8; after ready returns, next value is 0xC.
- branch_i=1 with target 0x100 while stall_i=1 for 2 cycles, then stall_i=0 → pc_o=0x100 throughout, then 0x104; redirect_o pulses exactly once.
- Same cycle exc_i=1, branch_i=1 (target 0x200) → pc_o=0x20 next cycle; eret_i with epc_i=0x44 → pc_o=0x44.
- branch target 0x102 → misalign_o=1 while pc_o=0x102. pc_o=0xFFFF_FFFC sequential → wraps to 0x0.
- PC_RAS_EN: call at pc_o=0x10 pushes 0x14; ret_i → pc_o=0x14. ret_i on empty stack → no redirect, sequential increment. Five pushes with depth 4 → pops return the last four pushed entries.
